// File: rtl/mem_arbiter_if.sv
// Requester-side port of the two-master memory arbiter.
// The requester drives master, the arbiter sits on slave.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  write;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [3:0]            write_mask;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  ack;

  modport master (
    output req, write, address,
    output data_in, write_mask,
    input  data_out, ack
  );

  modport slave (
    input  req, write, address,
    input  data_in, write_mask,
    output data_out, ack
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory_bus between two masters.
// One access in flight: enable cycle, then fixed read latency.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_arbiter_if.slave          m0,
  mem_arbiter_if.slave          m1,
  output logic [ADDR_WIDTH-1:0] bus_address,
  output logic [DATA_WIDTH-1:0] bus_data_in,
  output logic [3:0]            bus_write_mask,
  output logic                  bus_enable,
  output logic                  bus_write_enable,
  input  logic [DATA_WIDTH-1:0] bus_data_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT
  } state_t;

  localparam logic [2:0] LAT_M1 =
    3'(READ_LATENCY - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       last_q;
  logic       cur_q;
  logic       wr_q;
  logic       el0, el1;
  logic       pick;
  logic       grant;
  logic       done;

  // A port still holding req during its ack is not eligible
  assign el0  = m0.req & ~m0.ack;
  assign el1  = m1.req & ~m1.ack;
  assign pick = el1 & (~el0 | ~last_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (el0 | el1) begin
          grant   = 1'b1;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cnt_d   = LAT_M1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q           <= 1'b1;
      cur_q            <= 1'b0;
      wr_q             <= 1'b0;
      bus_address      <= '0;
      bus_data_in      <= '0;
      bus_write_mask   <= 4'b1111;
      bus_enable       <= 1'b0;
      bus_write_enable <= 1'b0;
      m0.ack           <= 1'b0;
      m1.ack           <= 1'b0;
      m0.data_out      <= '0;
      m1.data_out      <= '0;
    end else begin
      bus_enable       <= grant;
      bus_write_enable <= grant &
        (pick ? m1.write : m0.write);
      m0.ack           <= done & ~cur_q;
      m1.ack           <= done & cur_q;
      if (grant) begin
        last_q         <= pick;
        cur_q          <= pick;
        wr_q           <= pick ? m1.write
                               : m0.write;
        bus_address    <= pick ? m1.address
                               : m0.address;
        bus_data_in    <= pick ? m1.data_in
                               : m0.data_in;
        bus_write_mask <= pick ? m1.write_mask
                               : m0.write_mask;
      end
      // Writes leave the requester's read data untouched
      if (done & ~wr_q) begin
        if (cur_q) m1.data_out <= bus_data_out;
        else       m0.data_out <= bus_data_out;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: bus memory model, two requester drivers,
// scoreboard queues for grants and per-port acks.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int RL = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();

  logic [AW-1:0] bus_address;
  logic [DW-1:0] bus_data_in;
  logic [3:0]    bus_write_mask;
  logic          bus_enable;
  logic          bus_write_enable;
  logic [DW-1:0] bus_data_out;

  mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .m0(m0_if.slave),
    .m1(m1_if.slave),
    .bus_address(bus_address),
    .bus_data_in(bus_data_in),
    .bus_write_mask(bus_write_mask),
    .bus_enable(bus_enable),
    .bus_write_enable(bus_write_enable),
    .bus_data_out(bus_data_out)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } rq_t;

  typedef struct {
    logic        we;
    logic [31:0] data;
  } ex_t;

  rq_t rq0[$], rq1[$];
  ex_t ex0[$], ex1[$];
  rq_t gq[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int gcyc   = 0, gprev = 0;
  int ack0_cyc = 0, ack1_cyc = 0;
  int raise0 = 0, raise1 = 0;
  int ack0_cnt = 0;
  logic        be_prev = 1'b0;
  logic [31:0] last0 = '0, last1 = '0;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] init_word(int i);
    return (i == 32'h1000) ? 32'h12345678
                           : (32'hC0DE0000 | i);
  endfunction

  // Memory behind the bus, registered read of RL=1
  bit [31:0] mem [16384];
  bit        mem_v [16384];
  bit [31:0] rd;
  assign bus_data_out = rd;

  always @(posedge clk) begin
    logic [31:0] w;
    int idx;
    idx = int'(bus_address[15:2]);
    w = mem_v[idx] ? mem[idx] : init_word(idx);
    if (bus_enable) begin
      if (bus_write_enable) begin
        for (int b = 0; b < 4; b++)
          if (!bus_write_mask[b]) w[8*b+:8] = bus_data_in[8*b+:8];
        mem[idx]   <= w;
        mem_v[idx] <= 1'b1;
      end else begin
        rd <= w;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference image, updated in program order by issue()
  bit [31:0] ref_mem [16384];
  bit        ref_v [16384];

  task automatic issue(int p, logic we, logic [15:0] a,
                       logic [31:0] d, logic [3:0] mk);
    rq_t r;
    ex_t e;
    logic [31:0] w;
    int idx;
    idx = int'(a[15:2]);
    w = ref_v[idx] ? ref_mem[idx] : init_word(idx);
    r = '{we, a, d, mk};
    e = '{we, w};
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (!mk[b]) w[8*b+:8] = d[8*b+:8];
      ref_mem[idx] = w;
      ref_v[idx]   = 1'b1;
    end
    gq.push_back(r);
    if (p == 0) begin
      rq0.push_back(r);
      ex0.push_back(e);
    end else begin
      rq1.push_back(r);
      ex1.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    rq_t r;
    if (reset) begin
      m0_if.req = 1'b0;
      m0_if.write = 1'b0;
      m0_if.address = '0;
      m0_if.data_in = '0;
      m0_if.write_mask = 4'hf;
      rq0.delete();
    end else begin
      if (m0_if.ack) m0_if.req = 1'b0;
      if (!m0_if.req && rq0.size() > 0) begin
        r = rq0.pop_front();
        m0_if.write = r.we;
        m0_if.address = r.addr;
        m0_if.data_in = r.data;
        m0_if.write_mask = r.mask;
        m0_if.req = 1'b1;
        raise0 = cyc;
      end
    end
  end

  always @(negedge clk) begin
    rq_t r;
    if (reset) begin
      m1_if.req = 1'b0;
      m1_if.write = 1'b0;
      m1_if.address = '0;
      m1_if.data_in = '0;
      m1_if.write_mask = 4'hf;
      rq1.delete();
    end else begin
      if (m1_if.ack) m1_if.req = 1'b0;
      if (!m1_if.req && rq1.size() > 0) begin
        r = rq1.pop_front();
        m1_if.write = r.we;
        m1_if.address = r.addr;
        m1_if.data_in = r.data;
        m1_if.write_mask = r.mask;
        m1_if.req = 1'b1;
        raise1 = cyc;
      end
    end
  end

  // Monitor and scoreboard
  always @(negedge clk) begin
    rq_t g;
    ex_t e;
    logic [31:0] x;
    if (reset) begin
      last0 = '0;
      last1 = '0;
      be_prev = 1'b0;
      gq.delete();
      ex0.delete();
      ex1.delete();
    end else begin
      if (bus_enable) begin
        chk("be_pulse", be_prev, 0);
        if (gq.size() == 0) chk("bus_unexp", 1, 0);
        else begin
          g = gq.pop_front();
          chk("bus_addr", bus_address, g.addr);
          chk("bus_we", bus_write_enable, g.we);
          chk("bus_mask", bus_write_mask, g.mask);
          chk("bus_din", bus_data_in, g.data);
        end
        gprev = gcyc;
        gcyc  = cyc;
      end else begin
        chk("bwe_idle", bus_write_enable, 0);
      end
      be_prev = bus_enable;
      if (m0_if.ack || m1_if.ack)
        chk("ack_excl", m0_if.ack & m1_if.ack, 0);
      if (m0_if.ack) begin
        ack0_cnt++;
        ack0_cyc = cyc;
        if (ex0.size() == 0) chk("ack0_unexp", 1, 0);
        else begin
          e = ex0.pop_front();
          x = e.we ? last0 : e.data;
          chk("m0_data", m0_if.data_out, x);
          chk("m0_lat", cyc - gcyc, 1 + RL);
          last0 = x;
        end
      end else begin
        chk("m0_hold", m0_if.data_out, last0);
      end
      if (m1_if.ack) begin
        ack1_cyc = cyc;
        if (ex1.size() == 0) chk("ack1_unexp", 1, 0);
        else begin
          e = ex1.pop_front();
          x = e.we ? last1 : e.data;
          chk("m1_data", m1_if.data_out, x);
          chk("m1_lat", cyc - gcyc, 1 + RL);
          last1 = x;
        end
      end else begin
        chk("m1_hold", m1_if.data_out, last1);
      end
    end
  end

  task automatic check_reset_vals(string tag);
    chk({tag, "_be"}, bus_enable, 0);
    chk({tag, "_bwe"}, bus_write_enable, 0);
    chk({tag, "_ack0"}, m0_if.ack, 0);
    chk({tag, "_ack1"}, m1_if.ack, 0);
    chk({tag, "_dout0"}, m0_if.data_out, 0);
    chk({tag, "_dout1"}, m1_if.data_out, 0);
    chk({tag, "_addr"}, bus_address, 0);
    chk({tag, "_din"}, bus_data_in, 0);
    chk({tag, "_mask"}, bus_write_mask, 4'hf);
  endtask

  task automatic wait_done(string tag, int maxc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (gq.size() == 0 && ex0.size() == 0 &&
          ex1.size() == 0 && rq0.size() == 0 &&
          rq1.size() == 0 && !m0_if.req && !m1_if.req)
        ok = 1'b1;
    end
    if (!ok) chk({tag, "_timeout"}, 0, 1);
    @(negedge clk);
  endtask

  task automatic kick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int saved;
    bit seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;

    // single read
    kick();
    issue(0, 0, 16'h4000, 32'h0, 4'hf);
    wait_done("rd", 40);
    chk("rd_val", m0_if.data_out, 32'h12345678);

    // single write then readback
    kick();
    issue(1, 1, 16'h8004, 32'hAABBCCDD, 4'b1100);
    wait_done("wr", 40);
    chk("wr_dout1", m1_if.data_out, 0);
    kick();
    issue(0, 0, 16'h8004, 32'h0, 4'hf);
    wait_done("rb", 40);
    chk("rb_low", m0_if.data_out[15:0], 16'hCCDD);

    // tie after reset
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    kick();
    issue(0, 0, 16'h4000, 32'h0, 4'hf);
    issue(1, 0, 16'h4008, 32'h0, 4'hf);
    wait_done("tie", 60);
    chk("tie_total", ack1_cyc - raise0, 6);
    chk("tie_order", ack1_cyc - ack0_cyc, 3);

    // continuous contention
    kick();
    for (int i = 0; i < 4; i++) begin
      issue(0, 0, 16'h4100 + 16'(4 * i), 32'h0, 4'hf);
      issue(1, 0, 16'h8100 + 16'(4 * i), 32'h0, 4'hf);
    end
    wait_done("cont", 120);
    chk("cont_gap", gcyc - gprev, 3);

    // ack masking, back-to-back from one port
    kick();
    issue(0, 0, 16'h4200, 32'h0, 4'hf);
    issue(0, 0, 16'h4204, 32'h0, 4'hf);
    wait_done("mask", 60);
    chk("mask_gap", gcyc - gprev, 4);

    // reset during ACCESS
    kick();
    issue(0, 0, 16'h4300, 32'h0, 4'hf);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus_enable) seen = 1'b1;
    end
    if (!seen) chk("midrst_timeout", 0, 1);
    saved = ack0_cnt;
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst_noack", ack0_cnt, saved);
    kick();
    issue(0, 0, 16'h4000, 32'h0, 4'hf);
    wait_done("post", 40);
    chk("post_val", m0_if.data_out, 32'h12345678);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
